ascon_serial_out: RTL and testbench

Output serializer for the AEAD cores. It captures the parallel result text (plaintext or ciphertext, `Y` bits) and the 128-bit tag when the core finishes. It then shifts both out one bit per advance, index 0 first, on two serial pins, matching the bit order the host reads. It sits between the AEAD datapath result registers and the `*xSO` serial output pins, and is shared by `AEADEncryption` and `AEADDecryption`.

---
 rtl/ascon_serial_out_pkg.sv | 18 +
 rtl/ascon_serial_out_if.sv | 29 ++
 rtl/ascon_serial_out.sv | 88 ++++++++
 tb/tb_ascon_serial_out.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_serial_out_pkg.sv
// Shared constants and state encoding for the Ascon AEAD result serializer
// and its mirror serial-to-parallel loader.
package ascon_serial_out_pkg;

  localparam int Y_DEF = 128;
  localparam int T_DEF = 128;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOADED = 2'd1,
    S_SHIFT  = 2'd2
  } ser_state_t;

  function automatic int max_width(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ascon_serial_out_if.sv
// Parallel capture and serial read-out bundle between the AEAD core, the
// serializer and the host-facing serial pins.
interface ascon_serial_out_if #(
  parameter int Y = 128,
  parameter int T = 128
);

  logic         load;
  logic [Y-1:0] text_in;
  logic [T-1:0] tag_in;
  logic         shift_en;
  logic         text_so;
  logic         tag_so;
  logic         ready_so;
  logic         busy;

  // Core/host side: supplies the result and advances the stream.
  modport master (
    output load, text_in, tag_in, shift_en,
    input  text_so, tag_so, ready_so, busy
  );

  // Serializer side.
  modport slave (
    input  load, text_in, tag_in, shift_en,
    output text_so, tag_so, ready_so, busy
  );

endinterface

// File: rtl/ascon_serial_out.sv
// Captures the AEAD result text and tag on a load pulse and streams both out
// LSB first, one bit per host advance; all outputs come straight from flops.
module ascon_serial_out
  import ascon_serial_out_pkg::*;
#(
  parameter int Y = Y_DEF,
  parameter int T = T_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ascon_serial_out_if.slave bus
);

  localparam int N  = max_width(Y, T);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  ser_state_t    state_r, state_s;
  logic [N-1:0]  text_r, text_s;
  logic [N-1:0]  tag_r, tag_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          active_r;

  // Next-state and datapath update; both registers widen to N so the
  // shorter one reads zero past its own width.
  always_comb begin
    state_s = state_r;
    text_s  = text_r;
    tag_s   = tag_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (bus.load) begin
          text_s  = N'(bus.text_in);
          tag_s   = N'(bus.tag_in);
          cnt_s   = '0;
          state_s = S_LOADED;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOADED, S_SHIFT: begin
        if (bus.shift_en) begin
          text_s = text_r >> 1;
          tag_s  = tag_r >> 1;
          cnt_s  = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_s = S_IDLE;
          end else begin
            state_s = S_SHIFT;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = S_IDLE;
        text_s  = '0;
        tag_s   = '0;
        cnt_s   = '0;
      end
    endcase
  end

  // State, shift registers, bit counter and the registered status flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= S_IDLE;
      text_r   <= '0;
      tag_r    <= '0;
      cnt_r    <= '0;
      active_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      text_r   <= text_s;
      tag_r    <= tag_s;
      cnt_r    <= cnt_s;
      active_r <= (state_s != S_IDLE);
    end
  end

  assign bus.text_so  = text_r[0];
  assign bus.tag_so   = tag_r[0];
  assign bus.ready_so = active_r;
  assign bus.busy     = active_r;

endmodule

// File: tb/tb_ascon_serial_out.sv
// Directed bench for the Ascon result serializer: 128/128 and 64/128 widths.
module tb_ascon_serial_out;
  import ascon_serial_out_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ascon_serial_out_if #(.Y(128), .T(128)) sif ();
  ascon_serial_out_if #(.Y(64),  .T(128)) wif ();

  ascon_serial_out #(.Y(128), .T(128)) dut   (.clk(clk), .rst(rst), .bus(sif.slave));
  ascon_serial_out #(.Y(64),  .T(128)) dut_w (.clk(clk), .rst(rst), .bus(wif.slave));

  int errors = 0;
  int checks = 0;

  logic [127:0] txt = 128'h0123456789abcdef_fedcba9876543210;
  logic [127:0] tag = 128'h00112233445566778899aabbccddeeff;
  logic [63:0]  wtxt = 64'hdeadbeefcafef00d;
  logic [127:0] rt, rg;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sif.load = 1'b0; sif.shift_en = 1'b0; sif.text_in = '0; sif.tag_in = '0;
    wif.load = 1'b0; wif.shift_en = 1'b0; wif.text_in = '0; wif.tag_in = '0;
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({sif.text_so, sif.tag_so, sif.ready_so, sif.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold: got %b want 0000", {sif.text_so, sif.tag_so, sif.ready_so, sif.busy});
    end
    checks++;
    if ({wif.text_so, wif.tag_so, wif.ready_so, wif.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold_w: got %b want 0000", {wif.text_so, wif.tag_so, wif.ready_so, wif.busy});
    end
    rst = 1'b1;
    tick();
    sif.shift_en = 1'b1;
    repeat (3) tick();
    sif.shift_en = 1'b0;
    checks++;
    if ({sif.text_so, sif.tag_so, sif.ready_so, sif.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_shift_ignored: got %b want 0000", {sif.text_so, sif.tag_so, sif.ready_so, sif.busy});
    end
  endtask

  task automatic test_basic();
    sif.text_in = txt; sif.tag_in = tag; sif.load = 1'b1;
    tick();
    sif.load = 1'b0;
    checks++;
    if ({sif.ready_so, sif.busy} !== 2'b11) begin
      errors++;
      $display("FAIL basic_load_latency: ready/busy=%b want 11", {sif.ready_so, sif.busy});
    end
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (sif.ready_so !== 1'b1) begin
        errors++;
        $display("FAIL basic_ready_early_drop: index %0d ready=%b want 1", i, sif.ready_so);
      end
      rt[i] = sif.text_so;
      rg[i] = sif.tag_so;
      sif.shift_en = 1'b1;
      tick();
    end
    sif.shift_en = 1'b0;
    checks++;
    if (rt !== txt) begin
      errors++;
      $display("FAIL basic_text: got %h want %h", rt, txt);
    end
    checks++;
    if (rg !== tag) begin
      errors++;
      $display("FAIL basic_tag: got %h want %h", rg, tag);
    end
    checks++;
    if ({sif.text_so, sif.tag_so, sif.ready_so, sif.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL basic_end_idle: got %b want 0000", {sif.text_so, sif.tag_so, sif.ready_so, sif.busy});
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    int cyc = 0;
    logic en;
    sif.text_in = txt; sif.tag_in = tag; sif.load = 1'b1;
    tick();
    sif.load = 1'b0;
    while (idx < 128 && cyc < 600) begin
      en = ((cyc % 3) == 0);
      checks++;
      if ({sif.ready_so, sif.text_so, sif.tag_so} !== {1'b1, txt[idx], tag[idx]}) begin
        errors++;
        $display("FAIL stall_bit: index %0d ready/text/tag=%b want %b", idx,
                 {sif.ready_so, sif.text_so, sif.tag_so}, {1'b1, txt[idx], tag[idx]});
      end
      sif.shift_en = en;
      tick();
      if (en) idx++;
      cyc++;
    end
    sif.shift_en = 1'b0;
    checks++;
    if (idx != 128) begin
      errors++;
      $display("FAIL stall_budget: advances %0d want 128", idx);
    end
    checks++;
    if ({sif.ready_so, sif.busy} !== 2'b00) begin
      errors++;
      $display("FAIL stall_end: ready/busy=%b want 00", {sif.ready_so, sif.busy});
    end
  endtask

  task automatic test_width_mismatch();
    logic exp_t;
    wif.text_in = wtxt; wif.tag_in = tag; wif.load = 1'b1;
    tick();
    wif.load = 1'b0;
    for (int i = 0; i < 128; i++) begin
      exp_t = (i < 64) ? wtxt[i] : 1'b0;
      checks++;
      if ({wif.ready_so, wif.text_so, wif.tag_so} !== {1'b1, exp_t, tag[i]}) begin
        errors++;
        $display("FAIL width_bit: index %0d ready/text/tag=%b want %b", i,
                 {wif.ready_so, wif.text_so, wif.tag_so}, {1'b1, exp_t, tag[i]});
      end
      wif.shift_en = 1'b1;
      tick();
    end
    wif.shift_en = 1'b0;
    checks++;
    if ({wif.ready_so, wif.busy} !== 2'b00) begin
      errors++;
      $display("FAIL width_end: ready/busy=%b want 00", {wif.ready_so, wif.busy});
    end
  endtask

  task automatic test_illegal_reload();
    sif.text_in = txt; sif.tag_in = tag; sif.load = 1'b1;
    tick();
    sif.load = 1'b0;
    sif.shift_en = 1'b1;
    repeat (10) tick();
    sif.shift_en = 1'b0;
    sif.text_in = ~txt; sif.tag_in = ~tag; sif.load = 1'b1;
    tick();
    sif.load = 1'b0;
    checks++;
    if (sif.busy !== 1'b1) begin
      errors++;
      $display("FAIL reload_busy: got %b want 1", sif.busy);
    end
    for (int i = 10; i < 128; i++) begin
      checks++;
      if ({sif.busy, sif.text_so, sif.tag_so} !== {1'b1, txt[i], tag[i]}) begin
        errors++;
        $display("FAIL reload_bit: index %0d busy/text/tag=%b want %b", i,
                 {sif.busy, sif.text_so, sif.tag_so}, {1'b1, txt[i], tag[i]});
      end
      sif.shift_en = 1'b1;
      tick();
    end
    sif.shift_en = 1'b0;
    checks++;
    if ({sif.ready_so, sif.busy} !== 2'b00) begin
      errors++;
      $display("FAIL reload_end: ready/busy=%b want 00", {sif.ready_so, sif.busy});
    end
  endtask

  task automatic test_async_abort();
    sif.text_in = tag; sif.tag_in = txt; sif.load = 1'b1;
    tick();
    sif.load = 1'b0;
    sif.shift_en = 1'b1;
    repeat (50) tick();
    sif.shift_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({sif.text_so, sif.tag_so, sif.ready_so, sif.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_outputs: got %b want 0000", {sif.text_so, sif.tag_so, sif.ready_so, sif.busy});
    end
    tick();
    rst = 1'b1;
    tick();
    sif.text_in = txt; sif.tag_in = tag; sif.load = 1'b1;
    tick();
    sif.load = 1'b0;
    for (int i = 0; i < 128; i++) begin
      checks++;
      if ({sif.ready_so, sif.text_so, sif.tag_so} !== {1'b1, txt[i], tag[i]}) begin
        errors++;
        $display("FAIL abort_restream: index %0d ready/text/tag=%b want %b", i,
                 {sif.ready_so, sif.text_so, sif.tag_so}, {1'b1, txt[i], tag[i]});
      end
      sif.shift_en = 1'b1;
      tick();
    end
    sif.shift_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Load and shift together in IDLE: the load must win with no shift.
    sif.text_in = tag; sif.tag_in = txt; sif.load = 1'b1; sif.shift_en = 1'b1;
    tick();
    sif.load = 1'b0;
    for (int i = 0; i < 128; i++) begin
      checks++;
      if ({sif.ready_so, sif.text_so, sif.tag_so} !== {1'b1, tag[i], txt[i]}) begin
        errors++;
        $display("FAIL b2b_first: index %0d ready/text/tag=%b want %b", i,
                 {sif.ready_so, sif.text_so, sif.tag_so}, {1'b1, tag[i], txt[i]});
      end
      tick();
    end
    sif.shift_en = 1'b0;
    sif.text_in = ~txt; sif.tag_in = ~tag; sif.load = 1'b1;
    tick();
    sif.load = 1'b0;
    for (int i = 0; i < 128; i++) begin
      checks++;
      if ({sif.ready_so, sif.text_so, sif.tag_so} !== {1'b1, ~txt[i], ~tag[i]}) begin
        errors++;
        $display("FAIL b2b_second: index %0d ready/text/tag=%b want %b", i,
                 {sif.ready_so, sif.text_so, sif.tag_so}, {1'b1, ~txt[i], ~tag[i]});
      end
      sif.shift_en = 1'b1;
      tick();
    end
    sif.shift_en = 1'b0;
    checks++;
    if ({sif.text_so, sif.tag_so, sif.ready_so, sif.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_end: got %b want 0000", {sif.text_so, sif.tag_so, sif.ready_so, sif.busy});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_width_mismatch();
    test_illegal_reload();
    test_async_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
